// File: rtl/k_rom_sched.sv
// Round-robin scheduler sharing a single-port coefficient ROM between two burst requesters.
// Grants one burst at a time and returns owner-tagged data, forced to zero outside valid beats.
module k_rom_sched #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [AWIDTH-1:0] base0,
  input  logic [AWIDTH-1:0] base1,
  input  logic [AWIDTH:0]   len0,
  input  logic [AWIDTH:0]   len1,
  output logic              grant0,
  output logic              grant1,
  output logic              done0,
  output logic              done1,
  output logic              rom_en,
  output logic [AWIDTH-1:0] rom_addr,
  input  logic [DWIDTH-1:0] rom_data,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_id,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t            state, state_nxt;
  logic              prio, prio_nxt;
  logic              owner, owner_nxt;
  logic              zlen, zlen_nxt;
  logic [AWIDTH-1:0] addr_cnt, addr_nxt;
  logic [AWIDTH:0]   rem, rem_nxt;
  logic [AWIDTH:0]   len_sel;
  logic              arb_ok, win, win_id;
  logic              vld_p1, id_p1;

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    owner_nxt = owner;
    zlen_nxt  = zlen;
    addr_nxt  = addr_cnt;
    rem_nxt   = rem;
    // A zero-length grant spends one DRAIN cycle before its done, so it does not arbitrate.
    arb_ok    = (state == IDLE) || ((state == DRAIN) && !zlen);
    win       = arb_ok && (req0 || req1);
    win_id    = prio ? req1 : ~req0;
    len_sel   = win_id ? len1 : len0;

    case (state)
      BURST: begin
        addr_nxt = addr_cnt + 1'b1;
        rem_nxt  = rem - 1'b1;
        if (rem == {{AWIDTH{1'b0}}, 1'b1}) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (zlen) zlen_nxt  = 1'b0;
        else      state_nxt = IDLE;
      end
      default: ;
    endcase

    if (win) begin
      owner_nxt = win_id;
      prio_nxt  = ~win_id;
      addr_nxt  = win_id ? base1 : base0;
      rem_nxt   = len_sel;
      zlen_nxt  = (len_sel == '0);
      state_nxt = (len_sel == '0) ? DRAIN : BURST;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      prio   <= 1'b0;
      owner  <= 1'b0;
      zlen   <= 1'b0;
      grant0 <= 1'b0;
      grant1 <= 1'b0;
      vld_p1 <= 1'b0;
      id_p1  <= 1'b0;
    end else begin
      state  <= state_nxt;
      prio   <= prio_nxt;
      owner  <= owner_nxt;
      zlen   <= zlen_nxt;
      grant0 <= win && !win_id;
      grant1 <= win && win_id;
      // stage p1: ROM read returns one cycle after the enable
      vld_p1 <= rom_en;
      id_p1  <= owner;
    end
  end

  always_ff @(posedge clk) begin
    addr_cnt <= addr_nxt;
    rem      <= rem_nxt;
  end

  assign rom_en   = (state == BURST);
  assign rom_addr = rom_en ? addr_cnt : '0;
  assign done0    = (state == DRAIN) && !zlen && !owner;
  assign done1    = (state == DRAIN) && !zlen && owner;
  assign busy     = (state != IDLE);
  assign rd_valid = vld_p1;
  assign rd_id    = id_p1;
  // The ROM floats its output when not enabled; never let that reach the consumer.
  assign rd_data  = vld_p1 ? rom_data : '0;

endmodule

// File: tb/tb_k_rom_sched.sv
// Bench for k_rom_sched: directed scenarios plus random traffic against a burst-level schedule model.
module tb_k_rom_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [3:0]  base0 = '0, base1 = '0;
  logic [4:0]  len0 = '0, len1 = '0;
  logic        grant0, grant1, done0, done1, rom_en, rd_valid, rd_id, busy;
  logic [3:0]  rom_addr;
  logic [15:0] rd_data;
  wire  [15:0] rom_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  k_rom_sched #(.DWIDTH(16), .AWIDTH(4)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .base0(base0), .base1(base1), .len0(len0), .len1(len1),
    .grant0(grant0), .grant1(grant1), .done0(done0), .done1(done1),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_id(rd_id), .busy(busy)
  );

  // ROM model: registered read, output floats when the previous cycle had no enable
  logic [15:0] rom_mem [16];
  logic [15:0] rom_q = '0;
  logic        rom_drv = 1'b0;
  initial begin
    for (int i = 0; i < 16; i++) rom_mem[i] = 16'h0000;
    rom_mem[0] = 16'h2000; rom_mem[1] = 16'h2000;
    rom_mem[2] = 16'h1400; rom_mem[3] = 16'h1400;
  end
  always @(posedge clk) begin
    if (rom_en) rom_q <= rom_mem[rom_addr];
    rom_drv <= rom_en;
  end
  assign rom_data = rom_drv ? rom_q : 16'hzzzz;

  // Schedule model: one record per granted burst (grant cycle, owner, base, length)
  int   cyc = 0;
  logic m_act = 1'b0;
  logic m_own = 1'b0;
  logic m_prio = 1'b0;
  int   m_g = 0, m_len = 0, m_base = 0;

  always @(posedge clk) begin
    int   span, k;
    logic w;
    span = (m_len == 0) ? 1 : m_len;
    k    = cyc - m_g;
    if (rst) begin
      m_act  <= 1'b0;
      m_prio <= 1'b0;
    end else if ((!m_act || k >= span) && (req0 || req1)) begin
      if (!m_prio) w = req0 ? 1'b0 : 1'b1;
      else         w = req1 ? 1'b1 : 1'b0;
      m_act  <= 1'b1;
      m_own  <= w;
      m_g    <= cyc + 1;
      m_len  <= w ? int'(len1) : int'(len0);
      m_base <= w ? int'(base1) : int'(base0);
      m_prio <= ~w;
    end
    cyc <= cyc + 1;
  end

  wire [27:0] obs = {grant0, grant1, done0, done1, busy, rom_en, rom_addr,
                     rd_valid, (rd_valid & rd_id), rd_data};

  function automatic logic [27:0] model_vec();
    logic g0, g1, d0, d1, bz, en, vl, id;
    logic [3:0]  ad;
    logic [15:0] dt;
    int k, span;
    {g0, g1, d0, d1, bz, en, vl, id} = '0;
    ad = '0;
    dt = '0;
    if (m_act) begin
      k    = cyc - m_g;
      span = (m_len == 0) ? 1 : m_len;
      if (k == 0)    begin g0 = !m_own; g1 = m_own; end
      if (k == span) begin d0 = !m_own; d1 = m_own; end
      bz = (k >= 0) && (k <= span);
      if (m_len > 0 && k >= 0 && k < m_len) begin
        en = 1'b1;
        ad = 4'((m_base + k) % 16);
      end
      if (m_len > 0 && k >= 1 && k <= m_len) begin
        vl = 1'b1;
        id = m_own;
        dt = rom_mem[(m_base + k - 1) % 16];
      end
    end
    return {g0, g1, d0, d1, bz, en, ad, vl, id, dt};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== 28'h0 || rd_id !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%h rd_id=%b expected all zero", obs, rd_id);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [15:0] exp_d [4];
    exp_d = '{16'h2000, 16'h2000, 16'h1400, 16'h1400};
    base0 = 4'd0; len0 = 5'd4; req0 = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL single_model k=%0d got=%h expected=%h", k, obs, model_vec());
      end
      if (k == 1) begin
        checks++;
        if (grant0 !== 1'b1 || rom_addr !== 4'd0) begin
          errors++;
          $display("FAIL single_grant got grant0=%b addr=%0d expected 1/0", grant0, rom_addr);
        end
      end
      if (k >= 2 && k <= 5) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_id !== 1'b0 || rd_data !== exp_d[k-2]) begin
          errors++;
          $display("FAIL single_data k=%0d got=%h/%b/%b expected=%h/1/0", k, rd_data, rd_valid, rd_id, exp_d[k-2]);
        end
      end
      if (k == 5) begin
        checks++;
        if (done0 !== 1'b1) begin
          errors++;
          $display("FAIL single_done got=%b expected=1", done0);
        end
      end
      if (k == 6) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL single_busy_fall got=%b expected=0", busy);
        end
      end
      if (grant0) req0 = 1'b0;
    end
  endtask

  task automatic test_wrap();
    base1 = 4'd14; len1 = 5'd4; req1 = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL wrap_model k=%0d got=%h expected=%h", k, obs, model_vec());
      end
      if (k == 3) begin
        checks++;
        if (rom_addr !== 4'd0 || rom_en !== 1'b1) begin
          errors++;
          $display("FAIL wrap_addr got=%0d en=%b expected 0/1", rom_addr, rom_en);
        end
      end
      if (k == 5) begin
        checks++;
        if (done1 !== 1'b1 || rd_data !== 16'h2000 || rd_id !== 1'b1) begin
          errors++;
          $display("FAIL wrap_last got done1=%b data=%h id=%b expected 1/2000/1", done1, rd_data, rd_id);
        end
      end
      if (grant1) req1 = 1'b0;
    end
  endtask

  task automatic test_contention();
    logic seq [$];
    base0 = 4'd2; len0 = 5'd2; base1 = 4'd0; len1 = 5'd2;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL contend_model k=%0d got=%h expected=%h", k, obs, model_vec());
      end
      if (k == 1 || k == 4) begin
        checks++;
        if (grant0 !== (k == 1) || grant1 !== (k == 4)) begin
          errors++;
          $display("FAIL contend_grant k=%0d got g0=%b g1=%b", k, grant0, grant1);
        end
      end
      if (grant0) req0 = 1'b0;
      if (grant1) req1 = 1'b0;
    end
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL held_model k=%0d got=%h expected=%h", k, obs, model_vec());
      end
      if (grant0) seq.push_back(1'b0);
      if (grant1) seq.push_back(1'b1);
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (seq.size() < 4) begin
      errors++;
      $display("FAIL held_grant_count got=%0d expected>=4", seq.size());
    end
    for (int i = 0; i < seq.size(); i++) begin
      checks++;
      if (seq[i] !== i[0]) begin
        errors++;
        $display("FAIL held_alternate idx=%0d got=%b expected=%b", i, seq[i], i[0]);
      end
    end
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL held_tail_model got=%h expected=%h", obs, model_vec());
      end
    end
  endtask

  task automatic test_zero_len();
    base0 = 4'd5; len0 = 5'd0; req0 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== model_vec() || rom_en !== 1'b0 || rd_valid !== 1'b0) begin
        errors++;
        $display("FAIL zero_model k=%0d got=%h expected=%h", k, obs, model_vec());
      end
      if (k == 1 || k == 2) begin
        checks++;
        if (grant0 !== (k == 1) || done0 !== (k == 2)) begin
          errors++;
          $display("FAIL zero_pulses k=%0d got grant0=%b done0=%b", k, grant0, done0);
        end
      end
      if (grant0) req0 = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    base0 = 4'd0; len0 = 5'd8; req0 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL rstmid_model k=%0d got=%h expected=%h", k, obs, model_vec());
      end
      if (k == 3) begin
        checks++;
        if (obs !== 28'h0 || rd_id !== 1'b0) begin
          errors++;
          $display("FAIL rstmid_clear got=%h id=%b expected zero", obs, rd_id);
        end
        rst = 1'b0;
      end
      if (k > 3) begin
        checks++;
        if (done0 !== 1'b0) begin
          errors++;
          $display("FAIL rstmid_no_done k=%0d got=%b expected=0", k, done0);
        end
      end
      if (grant0) req0 = 1'b0;
      if (k == 2) rst = 1'b1;
    end
    base1 = 4'd2; len1 = 5'd3; req1 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL rstmid_req1_model k=%0d got=%h expected=%h", k, obs, model_vec());
      end
      if (k == 1) begin
        checks++;
        if (grant1 !== 1'b1) begin
          errors++;
          $display("FAIL rstmid_grant1 got=%b expected=1", grant1);
        end
      end
      if (grant1) req1 = 1'b0;
    end
  endtask

  task automatic test_idle();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (rd_data !== 16'h0 || rd_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_gate k=%0d got data=%h valid=%b expected 0/0", k, rd_data, rd_valid);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL random_model c=%0d got=%h expected=%h", c, obs, model_vec());
      end
      if (grant0) req0 = 1'b0;
      if (grant1) req1 = 1'b0;
      if (!req0 && $urandom_range(0, 3) == 0) begin
        base0 = 4'($urandom_range(0, 15));
        len0  = 5'($urandom_range(0, 16));
        req0  = 1'b1;
      end
      if (!req1 && $urandom_range(0, 3) == 0) begin
        base1 = 4'($urandom_range(0, 15));
        len1  = 5'($urandom_range(0, 16));
        req1  = 1'b1;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL random_tail_model got=%h expected=%h", obs, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_contention();
    test_zero_len();
    test_reset_mid();
    test_idle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/k_rom_sched.md
# k_rom_sched

Round-robin scheduler that shares the single-port coefficient ROM (k-constant store, 16 x 16-bit, read-enable plus address, one-cycle registered read) between two requesters: the forward-pass unit (port 0) and the weight-update unit (port 1). Each requester asks for a burst of consecutive coefficients. The scheduler grants one burst at a time, drives the ROM enable and address, and returns the data tagged with the owner's ID. Because the ROM output is high-impedance whenever its enable is low, the scheduler also forces returned data to zero outside valid cycles.

## Interface
- DWIDTH, 16, coefficient data width
- AWIDTH, 4, ROM address width (2**AWIDTH entries)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- req0 / req1  input  1  burst request, level; held until the matching grant
- base0 / base1  input  AWIDTH  first ROM address of the burst; stable while req is high
- len0 / len1  input  AWIDTH+1  burst length, 0..16
- grant0 / grant1  output  1  one-cycle pulse; base/len captured in this cycle
- done0 / done1  output  1  one-cycle pulse with the last data beat of the burst (or alone, for len=0)
- rom_en  output  1  ROM read enable
- rom_addr  output  AWIDTH  ROM address
- rom_data  input  DWIDTH  ROM output (Z when not enabled)
- rd_data  output  DWIDTH  returned coefficient; 0 when rd_valid=0
- rd_valid  output  1  rd_data is valid
- rd_id  output  1  owner of the current beat (0 or 1)
- busy  output  1  high in BURST and DRAIN

## Operation
- FSM states are IDLE, BURST, and DRAIN.
- Arbitration is evaluated in IDLE and DRAIN only. The winner is chosen by the rotating priority pointer `prio`:
  - prio=0: req0 wins over req1. prio=1: req1 wins over req0.
  - After a grant to port i, prio becomes the other port.
  - Reset sets prio=0.
- On a win at an edge:
  - The next cycle asserts grant_i (registered pulse).
  - addr_cnt is loaded with base_i and rem is loaded with len_i.
  - The state becomes BURST if len_i>0, otherwise DRAIN.
- BURST:
  - rom_en=1 and rom_addr=addr_cnt.
  - Each cycle, addr_cnt increments modulo 2**AWIDTH (15 wraps to 0) and rem decrements.
  - When rem=1, the next state is DRAIN.
- DRAIN:
  - rom_en=0.
  - The last beat is returned (for len>0) and done_i pulses.
  - If a request is pending, the next state is BURST/DRAIN for the new winner; otherwise IDLE.
- Return path:
  - rd_valid is rom_en delayed by one cycle.
  - rd_id is the owner delayed by one cycle.
  - rd_data = rd_valid ? rom_data : 0. The ROM's Z output must never propagate.
- len=0: a grant is given and done_i pulses in the following DRAIN cycle. No ROM access occurs and rd_valid stays 0.
- A requester still holding req in DRAIN after its own done is treated as a new request and competes normally under the pointer.
- Inputs on the non-granted port are ignored during a burst. Its req keeps waiting; no data is lost.

## Timing
- Reset values: grant0/1=0, done0/1=0, rom_en=0, rom_addr=0, rd_valid=0, rd_data=0, rd_id=0, busy=0, state=IDLE, prio=0.
- Single burst:
  - req sampled high in IDLE at cycle 0.
  - Cycle 1: grant pulses and the first rom_en occurs.
  - rom_en stays high in cycles 1..L.
  - rd_valid is high in cycles 2..L+1.
  - done pulses in cycle L+1 (DRAIN).
- Read latency is 1 cycle from rom_en to rd_valid.
- Back-to-back bursts: the next grant and first rom_en fall in cycle L+2, giving one cycle of rom_en=0 between bursts. Throughput is L beats per L+1 cycles.
- Simultaneous req0 and req1 in IDLE: resolved by prio in the same cycle. The loser is granted right after the winner's DRAIN.
- Reset mid-burst: on the reset edge, all outputs return to their reset values, the burst is abandoned, no done is issued, and prio is cleared.

## Test plan
The bench ROM model holds 0x2000 at addresses 0-1, 0x1400 at addresses 2-3, and 0 elsewhere.
- Single burst: req0, base0=0, len0=4 → grant0 in cycle 1; rom_addr 0,1,2,3 in cycles 1-4; rd_data 0x2000,0x2000,0x1400,0x1400 with rd_id=0 in cycles 2-5; done0 in cycle 5; busy falls in cycle 6.
- Wrap-around: req1, base1=14, len1=4 → rom_addr 14,15,0,1; rd_data 0,0,0x2000,0x2000 with rd_id=1; done1 with the 4th beat.
- Contention: req0 and req1 both raised at cycle 0 with len=2 each, both held → port 0 served first (grant0 in cycle 1), grant1 in cycle 4. Repeat with both held continuously → grants alternate 0,1,0,1.
- Zero length: req0, len0=0 → grant0 pulse, then done0 the next cycle, with rom_en and rd_valid never asserted.
- Reset mid-burst: assert rst during beat 2 of a len=8 burst → next cycle all outputs 0, no done0. A subsequent req1 is granted ahead of req0 (prio=0 but only req1 pending), and the burst then proceeds normally.
- Idle gating: with no requests, rd_data=0 and rd_valid=0 every cycle, including while the ROM model drives Z.
